// File: rtl/sram_pio_pkg.sv
// sram_pio_pkg: shared types and constants for the SRAM PIO responder
package sram_pio_pkg;
    localparam int DEF_ADDR_WIDTH = 11;
    localparam int DEF_DATA_WIDTH = 8;
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;
    typedef enum logic [1:0] {CLEAR, IDLE, ACCESS, HOLD} state_t;
endpackage

// File: rtl/sram_pio_array.sv
// sram_pio_array: single-port synchronous RAM with registered read data
module sram_pio_array #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    // write port and registered read of the same address
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        o_rdata <= r_mem[i_addr];
    end
endmodule

// File: rtl/sram_pio_responder.sv
// sram_pio_responder: enable/done handshake responder over a zero-filled byte SRAM
module sram_pio_responder
    import sram_pio_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  chipSelect,
    input  logic                  enable,
    input  logic                  readnWrite,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  done,
    output logic                  busy
);
    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_cnt, r_addr, w_addr;
    logic [DATA_WIDTH-1:0] r_wdata, r_dout, w_wdata, w_rdata;
    logic                  r_en_prev, r_rnw, w_we, w_start;

    assign w_start = enable & ~r_en_prev & chipSelect;
    assign dataOut = r_dout;
    assign done    = (r_state == HOLD);
    assign busy    = (r_state == CLEAR);

    // IDLE presents the live address so the registered read is ready by the ACCESS edge
    always_comb begin
        w_next  = r_state;
        w_we    = 1'b0;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        case (r_state)
            CLEAR: begin
                w_we    = 1'b1;
                w_addr  = r_cnt;
                w_wdata = '0;
                w_next  = &r_cnt ? IDLE : CLEAR;
            end
            IDLE: begin
                w_addr = address;
                w_next = w_start ? ACCESS : IDLE;
            end
            ACCESS: begin
                w_we   = (r_rnw == WRITE);
                w_next = HOLD;
            end
            HOLD: w_next = enable ? HOLD : IDLE;
            default: w_next = IDLE;
        endcase
        if (reset) w_we = 1'b0;
    end

    // state, edge detect, clear counter, access latches and read data register
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state   <= CLEAR_ON_RESET ? CLEAR : IDLE;
            r_cnt     <= '0;
            r_en_prev <= 1'b0;
            r_dout    <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rnw     <= READ;
        end else begin
            r_state   <= w_next;
            r_en_prev <= enable;
            if (r_state == CLEAR) r_cnt <= r_cnt + 1'b1;
            if (r_state == IDLE && w_start) begin
                r_addr  <= address;
                r_wdata <= dataIn;
                r_rnw   <= readnWrite;
            end
            if (r_state == ACCESS && r_rnw == READ) r_dout <= w_rdata;
        end
    end

    sram_pio_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_array (
        .i_clk  (CLK),
        .i_we   (w_we),
        .i_addr (w_addr),
        .i_wdata(w_wdata),
        .o_rdata(w_rdata)
    );
endmodule

// File: tb/tb_sram_pio_responder.sv
// tb_sram_pio_responder: directed self-checking bench for sram_pio_responder
module tb_sram_pio_responder;
    logic        CLK = 1'b0;
    logic        reset;
    logic [7:0]  dataIn;
    logic [10:0] address;
    logic        chipSelect;
    logic        enable;
    logic        readnWrite;
    logic [7:0]  dataOut;
    logic        done;
    logic        busy;
    int          n_checks = 0;
    int          n_fail = 0;

    sram_pio_responder dut (
        .CLK       (CLK),
        .reset     (reset),
        .dataIn    (dataIn),
        .address   (address),
        .chipSelect(chipSelect),
        .enable    (enable),
        .readnWrite(readnWrite),
        .dataOut   (dataOut),
        .done      (done),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clear(input string tag, input int exp);
        int n = 0;
        while (busy === 1'b1 && n < 3000) begin
            cyc();
            n++;
        end
        chk(tag, n, exp);
    endtask

    task automatic access(input logic rnw, input logic [10:0] a, input logic [7:0] d, input string tag);
        address = a;
        dataIn = d;
        readnWrite = rnw;
        chipSelect = 1'b1;
        enable = 1'b1;
        cyc();
        chk({tag, " done at t"}, done, 0);
        cyc();
        chk({tag, " done at t+1"}, done, 1);
        enable = 1'b0;
        cyc();
        chk({tag, " done drop"}, done, 0);
        chipSelect = 1'b0;
        cyc();
    endtask

    task automatic rd(input logic [10:0] a, input logic [7:0] exp, input string tag);
        access(1'b1, a, 8'h00, tag);
        chk({tag, " data"}, dataOut, exp);
    endtask

    initial begin
        int hi;
        reset = 1'b1;
        dataIn = '0;
        address = '0;
        chipSelect = 1'b0;
        enable = 1'b0;
        readnWrite = 1'b1;
        repeat (3) cyc();
        chk("reset busy", busy, 1);
        chk("reset done", done, 0);
        chk("reset dataOut", dataOut, 0);
        reset = 1'b0;
        wait_clear("clear length", 2048);
        rd(11'h000, 8'h00, "clr rd 0");
        rd(11'h3FF, 8'h00, "clr rd 1023");
        rd(11'h7FF, 8'h00, "clr rd 2047");

        access(1'b0, 11'h12F, 8'hA5, "wr 12F");
        rd(11'h12F, 8'hA5, "rd 12F");
        rd(11'h130, 8'h00, "rd 130");

        rd(11'h12F, 8'hA5, "rd 12F again");
        address = 11'h040;
        dataIn = 8'h11;
        readnWrite = 1'b0;
        chipSelect = 1'b1;
        enable = 1'b1;
        cyc();
        cyc();
        chk("hold done set", done, 1);
        hi = 0;
        repeat (10) begin
            address = 11'h041;
            dataIn = 8'h22;
            readnWrite = 1'b1;
            chipSelect = 1'b0;
            cyc();
            hi += int'(done);
        end
        chk("hold done cycles", hi, 10);
        enable = 1'b0;
        cyc();
        chk("hold done drop", done, 0);
        chk("write keeps dataOut", dataOut, 8'hA5);
        cyc();
        rd(11'h040, 8'h11, "rd 040");
        rd(11'h041, 8'h00, "rd 041");

        address = 11'h050;
        dataIn = 8'h77;
        readnWrite = 1'b0;
        chipSelect = 1'b0;
        enable = 1'b1;
        hi = 0;
        repeat (4) begin
            cyc();
            hi += int'(done);
        end
        chipSelect = 1'b1;
        repeat (4) begin
            cyc();
            hi += int'(done);
        end
        chk("no-cs and late-cs done", hi, 0);
        enable = 1'b0;
        chipSelect = 1'b0;
        cyc();
        rd(11'h050, 8'h00, "rd 050");

        access(1'b0, 11'h7FF, 8'h3C, "wr 7FF");
        rd(11'h7FF, 8'h3C, "rd 7FF 3C");
        address = 11'h7FF;
        dataIn = 8'hFF;
        readnWrite = 1'b0;
        chipSelect = 1'b1;
        enable = 1'b1;
        cyc();
        chk("midop access busy", busy, 0);
        reset = 1'b1;
        enable = 1'b0;
        cyc();
        chk("midop reset done", done, 0);
        chk("midop reset busy", busy, 1);
        chk("midop reset dataOut", dataOut, 0);
        reset = 1'b0;
        repeat (100) cyc();
        address = 11'h7FF;
        dataIn = 8'h99;
        readnWrite = 1'b0;
        chipSelect = 1'b1;
        enable = 1'b1;
        wait_clear("clear after midop", 1948);
        hi = 0;
        repeat (4) begin
            cyc();
            hi += int'(done);
        end
        chk("enable across clear", hi, 0);
        enable = 1'b0;
        chipSelect = 1'b0;
        cyc();
        rd(11'h7FF, 8'h00, "rd 7FF after clear");

        reset = 1'b1;
        cyc();
        reset = 1'b0;
        repeat (1000) cyc();
        chk("busy at 1000", busy, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        wait_clear("clear restart", 2048);

        rd(11'h12F, 8'h00, "rd 12F cleared");
        access(1'b0, 11'h12F, 8'hA5, "rewr 12F");
        rd(11'h12F, 8'hA5, "rerd 12F");
        for (int i = 0; i < 16; i++) access(1'b0, 11'(i), 8'(i) ^ 8'h55, "b2b wr");
        chk("b2b writes keep dataOut", dataOut, 8'hA5);
        for (int i = 0; i < 16; i++) rd(11'(i), 8'(i) ^ 8'h55, $sformatf("b2b rd %0d", i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
